// File: rtl/rom_reader.sv
// Read sequencer for a 2^AW x DW synchronous ROM: fetches count words from base_addr
// (wrapping) and streams them out on a valid/ready interface. Optional macro ROM_READER_LOOP_EN.
module rom_reader #(
  parameter int AW = 4,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   count,
  input  logic          abort,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_SEND  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [AW:0] REM_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] REM_ZERO = {(AW+1){1'b0}};

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW:0]   rem_q, rem_d;
  logic [DW-1:0] data_q, data_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
`ifdef ROM_READER_LOOP_EN
  logic [AW-1:0] base_q, base_d;
  logic [AW:0]   cnt_q, cnt_d;
`endif

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    data_d  = data_q;
    done_d  = 1'b0;
`ifdef ROM_READER_LOOP_EN
    base_d  = base_q;
    cnt_d   = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          addr_d = base_addr;
          rem_d  = count;
`ifdef ROM_READER_LOOP_EN
          base_d = base_addr;
          cnt_d  = count;
`endif
          if (count == REM_ZERO) begin
            state_d = S_DONE;
          end else begin
            state_d = S_FETCH;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          data_d  = rom_data;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (out_ready) begin
          rem_d  = rem_q - REM_ONE;
          addr_d = addr_q + {{(AW-1){1'b0}}, 1'b1};
          if (rem_q == REM_ONE) begin
`ifdef ROM_READER_LOOP_EN
            // Restart the table in place; done pulses while already fetching
            addr_d  = base_q;
            rem_d   = cnt_q;
            done_d  = 1'b1;
            state_d = S_FETCH;
`else
            state_d = S_DONE;
`endif
          end else begin
            state_d = S_FETCH;
          end
        end else begin
          state_d = S_SEND;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    done_d  = done_d | (state_d == S_DONE);
    valid_d = (state_d == S_SEND);
    busy_d  = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= {AW{1'b0}};
      rem_q   <= REM_ZERO;
      data_q  <= {DW{1'b0}};
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef ROM_READER_LOOP_EN
      base_q  <= {AW{1'b0}};
      cnt_q   <= REM_ZERO;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef ROM_READER_LOOP_EN
      base_q  <= base_d;
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign rom_addr  = addr_q;
  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_rom_reader.sv
// Scoreboard bench for rom_reader: a behavioural ROM feeds the DUT, expected words are
// queued at stimulus time and a monitor pops/compares them on every output handshake.
module tb_rom_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  base_addr;
  logic [4:0]  count;
  logic        abort;
  logic [3:0]  rom_addr;
  logic [15:0] rom_data;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  addr;
  } exp_t;

  exp_t sb_q[$];

  rom_reader #(.AW(4), .DW(16)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
    .abort(abort), .rom_addr(rom_addr), .rom_data(rom_data), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rom_word(input logic [3:0] a);
    case (a)
      4'd0:    return 16'h5601;
      4'd1:    return 16'h3401;
      4'd2:    return 16'h1801;
      4'd3:    return 16'h0AC1;
      4'd4:    return 16'h0561;
      4'd5:    return 16'h02B1;
      4'd6:    return 16'h5601;
      4'd7:    return 16'h5401;
      4'd8:    return 16'h2A01;
      4'd9:    return 16'h1501;
      4'd10:   return 16'h0A81;
      4'd11:   return 16'h0541;
      4'd12:   return 16'h02A1;
      4'd13:   return 16'h0151;
      4'd14:   return 16'h5601;
      default: return 16'h5401;
    endcase
  endfunction

  // Synchronous ROM with one-clock read latency
  always @(posedge clk) rom_data <= rom_word(rom_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic push(input logic [15:0] d, input logic [3:0] a);
    exp_t e;
    e.data = d;
    e.addr = a;
    sb_q.push_back(e);
  endtask

  // Output monitor: every handshake must match the head of the scoreboard
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_word", {16'h0, out_data}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_data", {16'h0, out_data}, {16'h0, e.data});
        chk("sb_rom_addr", {28'h0, rom_addr}, {28'h0, e.addr});
      end
    end
  end

  task automatic issue(input logic [3:0] b, input logic [4:0] c);
    @(negedge clk);
    start     = 1'b1;
    base_addr = b;
    count     = c;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Full-rate pass: word k at cycle 3k, done at 3n+1, busy through 3n+1
  task automatic expect_stream(input int n, input logic [3:0] b);
    for (int c = 1; c <= 3*n + 2; c++) begin
      @(negedge clk);
      if (c == 1) chk("first_rom_addr", {28'h0, rom_addr}, {28'h0, b});
      chk($sformatf("valid_c%0d", c), {31'h0, out_valid}, {31'h0, (c % 3 == 0) && (c <= 3*n)});
      chk($sformatf("done_c%0d", c), {31'h0, done}, {31'h0, c == 3*n + 1});
      chk($sformatf("busy_c%0d", c), {31'h0, busy}, {31'h0, c <= 3*n + 1});
    end
  endtask

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = 4'd0; count = 5'd0; abort = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rom_addr", {28'h0, rom_addr}, 32'h0);
    chk("rst_out_data", {16'h0, out_data}, 32'h0);
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    rst = 1'b0;

    // Zero count: done in cycle 1, busy only in cycle 1
    issue(4'd5, 5'd0);
    @(negedge clk);
    chk("zero_done_c1", {31'h0, done}, 32'h1);
    chk("zero_busy_c1", {31'h0, busy}, 32'h1);
    chk("zero_valid_c1", {31'h0, out_valid}, 32'h0);
    @(negedge clk);
    chk("zero_done_c2", {31'h0, done}, 32'h0);
    chk("zero_busy_c2", {31'h0, busy}, 32'h0);
    chk("zero_valid_c2", {31'h0, out_valid}, 32'h0);

`ifndef ROM_READER_LOOP_EN
    // Single pass from address 0
    push(16'h5601, 4'd0); push(16'h3401, 4'd1); push(16'h1801, 4'd2); push(16'h0AC1, 4'd3);
    issue(4'd0, 5'd4);
    expect_stream(4, 4'd0);
    chk("single_sb_empty", sb_q.size(), 32'h0);

    // Wrap past address 15
    push(16'h5601, 4'd14); push(16'h5401, 4'd15); push(16'h5601, 4'd0); push(16'h3401, 4'd1);
    issue(4'd14, 5'd4);
    expect_stream(4, 4'd14);
    chk("wrap_sb_empty", sb_q.size(), 32'h0);

    // Backpressure: out_ready low for cycles 3..7 of the first SEND
    push(16'h5601, 4'd0); push(16'h3401, 4'd1);
    out_ready = 1'b0;
    issue(4'd0, 5'd2);
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      if (c >= 3 && c <= 8) begin
        chk($sformatf("bp_valid_c%0d", c), {31'h0, out_valid}, 32'h1);
        chk($sformatf("bp_data_c%0d", c), {16'h0, out_data}, 32'h5601);
        chk($sformatf("bp_addr_c%0d", c), {28'h0, rom_addr}, 32'h0);
      end
      if (c == 8) out_ready = 1'b1;
      chk($sformatf("bp_done_c%0d", c), {31'h0, done}, {31'h0, c == 12});
      chk($sformatf("bp_busy_c%0d", c), {31'h0, busy}, {31'h0, c <= 12});
    end
    chk("bp_sb_empty", sb_q.size(), 32'h0);

    // Full table; a second start mid-transfer must be ignored
    for (int i = 0; i < 16; i++) push(rom_word(4'(3 + i)), 4'(3 + i));
    issue(4'd3, 5'd16);
    for (int c = 1; c <= 52; c++) begin
      @(negedge clk);
      if (c == 5) begin
        start = 1'b1; base_addr = 4'd9; count = 5'd2;
      end else begin
        start = 1'b0;
      end
      chk($sformatf("full_done_c%0d", c), {31'h0, done}, {31'h0, c == 49});
      chk($sformatf("full_busy_c%0d", c), {31'h0, busy}, {31'h0, c <= 49});
    end
    chk("full_sb_empty", sb_q.size(), 32'h0);

    // Abort in the 3rd SEND (cycle 9)
    push(16'h5601, 4'd0); push(16'h3401, 4'd1);
    issue(4'd0, 5'd8);
    repeat (8) @(negedge clk);
    @(posedge clk); #1 abort = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    chk("abort_valid_c9", {31'h0, out_valid}, 32'h1);
    chk("abort_data_c9", {16'h0, out_data}, 32'h1801);
    @(posedge clk); #1 abort = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("abort_valid_c10", {31'h0, out_valid}, 32'h0);
    chk("abort_busy_c10", {31'h0, busy}, 32'h0);
    chk("abort_done_c10", {31'h0, done}, 32'h0);
    @(negedge clk);
    chk("abort_done_c11", {31'h0, done}, 32'h0);
    chk("abort_sb_empty", sb_q.size(), 32'h0);

    // Reset in the 3rd SEND
    push(16'h5601, 4'd0); push(16'h3401, 4'd1);
    issue(4'd0, 5'd8);
    repeat (8) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    chk("rst_mid_addr_c9", {28'h0, rom_addr}, 32'h2);
    @(posedge clk); #1 rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("rst_mid_rom_addr", {28'h0, rom_addr}, 32'h0);
    chk("rst_mid_out_data", {16'h0, out_data}, 32'h0);
    chk("rst_mid_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_mid_busy", {31'h0, busy}, 32'h0);
    chk("rst_mid_done", {31'h0, done}, 32'h0);
    chk("rst_sb_empty", sb_q.size(), 32'h0);
`else
    // Looping: 6,7,6,7,... with done every 6 cycles, stopped by abort
    for (int i = 0; i < 3; i++) begin
      push(16'h5601, 4'd6); push(16'h5401, 4'd7);
    end
    issue(4'd6, 5'd2);
    for (int c = 1; c <= 19; c++) begin
      @(negedge clk);
      chk($sformatf("loop_valid_c%0d", c), {31'h0, out_valid}, {31'h0, c % 3 == 0});
      chk($sformatf("loop_done_c%0d", c), {31'h0, done}, {31'h0, (c == 7) || (c == 13) || (c == 19)});
      chk($sformatf("loop_busy_c%0d", c), {31'h0, busy}, 32'h1);
    end
    @(posedge clk); #1 abort = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("loop_abort_busy", {31'h0, busy}, 32'h0);
    chk("loop_abort_valid", {31'h0, out_valid}, 32'h0);
    chk("loop_abort_done", {31'h0, done}, 32'h0);
    chk("loop_sb_empty", sb_q.size(), 32'h0);
`endif

    repeat (3) @(negedge clk);
    chk("final_idle_busy", {31'h0, busy}, 32'h0);
    chk("final_sb_empty", sb_q.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rom_reader.md
# rom_reader

Read sequencer for the 16x16 synchronous ROM. On a start command it fetches `count` consecutive words from `base_addr`, wrapping modulo 16. It absorbs the ROM's one-clock registered read latency and presents each word on a valid/ready output stream. It sits between the ROM and any consumer of table data, such as a tone/divider player, and is the initiator for the ROM's address/data interface.

## Interface
- `AW`, 4: ROM address width (table depth 2^AW).
- `DW`, 16: ROM word width.
- `clk` input 1: single clock; all state changes on posedge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: command strobe; sampled only in IDLE.
- `base_addr` input AW: first word address; captured with `start`.
- `count` input AW+1: number of words, 0..16; captured with `start`.
- `abort` input 1: cancels any transfer in progress.
- `rom_addr` output AW: registered address to the ROM's `addr` port.
- `rom_data` input DW: from the ROM's `out`; valid one clock after `rom_addr` is sampled.
- `out_data` output DW: registered word to the consumer.
- `out_valid` output 1: `out_data` holds a word.
- `out_ready` input 1: consumer accepts; a word transfers on `out_valid & out_ready` at posedge.
- `busy` output 1: state is not IDLE.
- `done` output 1: one-cycle pulse after the last word of a command transfers.

## Operation
- States: IDLE, FETCH, WAIT, SEND, DONE.
- IDLE:
  - `start & !abort` captures `base_addr` into the address register and `count` into the remaining counter.
  - If `count == 0`, go to DONE and emit no words. Otherwise go to FETCH.
- FETCH: `rom_addr` holds the current address, and the ROM samples it at the closing edge. Go to WAIT.
- WAIT: `rom_data` is valid. Capture it into `out_data` at the closing edge. Go to SEND.
- SEND: `out_valid = 1`, and `out_data` is stable until the handshake. On handshake:
  - Decrement the remaining counter.
  - Increment the address modulo 2^AW (15 -> 0).
  - If the remaining counter reaches 0, go to DONE; otherwise go to FETCH.
- DONE: `done = 1` for exactly this cycle. Go to IDLE.
- `abort` in FETCH, WAIT, SEND or DONE: go to IDLE at the next edge.
  - `out_valid` and `done` drop.
  - No `done` pulse is emitted for the cancelled command.
  - In IDLE, `abort` has priority over a simultaneous `start`, which is ignored.
- `start` while `busy` is ignored and has no queuing.
- `rst` from any state: go to IDLE.
- Reset values: `rom_addr = 0`, `out_data = 0`, `out_valid = 0`, `busy = 0`, `done = 0`, remaining counter = 0.

## Timing
- `start` is sampled at edge E0.
- Cycle 1 (FETCH): `rom_addr = base_addr`.
- Cycle 2 (WAIT): `rom_data` is valid.
- Cycle 3 (SEND): `out_valid = 1`.
- With `out_ready` held high, each word takes 3 cycles and the next FETCH immediately follows a handshake.
- `done` is asserted in the cycle after the last handshake. `busy` falls one cycle later.
- `count == 0`: `done` in cycle 1, `busy` high in cycle 1 only.
- Backpressure only extends SEND. `rom_addr` does not change during SEND.
- Address arithmetic is AW-bit unsigned with natural wrap. The counter is AW+1 bits, so `count = 16` reads the whole table exactly once.

## Configuration
- Macro: `ROM_READER_LOOP_EN`.
- Defined:
  - After the last handshake, the block pulses `done` for one cycle while already in FETCH.
  - It reloads the captured `base_addr` and `count`, then repeats indefinitely.
  - Only `abort` or `rst` returns it to IDLE.
  - `count == 0` behaves as non-looping: it pulses `done` once and returns to IDLE.
- Not defined: single pass per `start`, as described in Operation.

## Test plan
- Single pass: `base_addr = 0`, `count = 4`, `out_ready = 1`.
  - Outputs 0x5601, 0x3401, 0x1801, 0x0AC1 at 3-cycle spacing, first at cycle 3 after `start`.
  - `done` pulses once, then `busy = 0`.
- Wrap: `base_addr = 14`, `count = 4`.
  - Outputs 0x5601, 0x5401, 0x5601, 0x3401.
  - `rom_addr` sequence is 14, 15, 0, 1.
- Backpressure: `count = 2`, with `out_ready` low for 5 cycles during the first SEND.
  - `out_data = 0x5601` stays stable with `out_valid` high throughout.
  - No word is lost or duplicated, and `rom_addr` is constant.
- Zero count and busy start:
  - `count = 0` gives `done` in cycle 1 and no `out_valid`.
  - A second `start` pulsed during a `count = 16` transfer is ignored, and exactly 16 words are emitted.
- Abort/reset mid-transfer: `count = 8`, `abort` asserted in the 3rd SEND.
  - IDLE next cycle, `out_valid = 0`, no `done`.
  - Repeat with `rst` instead: all outputs are 0 the next cycle.
- With `ROM_READER_LOOP_EN`: `base_addr = 6`, `count = 2`, `out_ready = 1`.
  - Outputs 0x5601, 0x5401, 0x5601, 0x5401, ...
  - `done` pulses every 6 cycles.
  - `abort` stops it.
